// File: rtl/psum_deskew_accum.sv
// psum_deskew_accum
// Takes the skewed row sums from a KERNEL_SIZE-row PE array and delays each
// row so that all rows of one output pixel line up on the same beat. It adds
// the aligned row sums, queues the results in a small output FIFO, and tracks
// frame boundaries with a four-state controller.
module psum_deskew_accum #(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int VERTICAL_SKEW = 2,
  parameter int FIFO_DEPTH    = 4,
  localparam int SUM_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
  localparam int OUT_WIDTH    = SUM_WIDTH + $clog2(KERNEL_SIZE)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             en,
  input  logic [15:0]                      frameLen,
  input  logic [SUM_WIDTH*KERNEL_SIZE-1:0] rowSumIn,
  input  logic                             rowSumIn_valid,
  output logic [OUT_WIDTH-1:0]             convOut,
  output logic                             convOut_valid,
  input  logic                             convOut_ready,
  output logic                             frame_done,
  output logic                             overflow
);

  // Number of beats needed before the first aligned set is complete.
  localparam int FILL_BEATS = (KERNEL_SIZE - 1) * VERTICAL_SKEW;
  localparam int FILL_W     = $clog2(FILL_BEATS + 2);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t              state_reg, state_next;
  logic [15:0]         frame_len_reg, frame_len_next;
  logic [FILL_W-1:0]   fill_cnt_reg, fill_cnt_next;
  logic [15:0]         res_cnt_reg, res_cnt_next;
  logic [15:0]         cur_len;
  logic                accept;
  logic                produce;

  logic [SUM_WIDTH-1:0] aligned [KERNEL_SIZE];
  logic [OUT_WIDTH-1:0] sum_next;
  logic [OUT_WIDTH-1:0] sum_reg;
  logic                 push_reg;

  logic [OUT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 fifo_full;
  logic                 pop;
  logic                 push_ok;
  logic                 overflow_reg;
  logic                 frame_done_reg;

  // Frame controller: decides which beats are consumed, which produce a result, and when the frame ends.
  always_comb begin
    state_next     = state_reg;
    frame_len_next = frame_len_reg;
    fill_cnt_next  = fill_cnt_reg;
    res_cnt_next   = res_cnt_reg;
    cur_len        = frame_len_reg;
    accept         = 1'b0;
    produce        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en && rowSumIn_valid) begin
          // frameLen is latched here and also used directly for this first beat.
          cur_len        = frameLen;
          frame_len_next = frameLen;
          if (frameLen == 16'd0) begin
            state_next = DONE;
          end else begin
            accept = 1'b1;
          end
        end
      end
      FILL, STREAM: begin
        // en is ignored once a frame has started. Only DONE ends the frame.
        accept = rowSumIn_valid;
      end
      DONE: begin
        state_next    = IDLE;
        fill_cnt_next = '0;
        res_cnt_next  = '0;
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      if (fill_cnt_reg == FILL_W'(FILL_BEATS)) begin
        produce      = 1'b1;
        res_cnt_next = res_cnt_reg + 16'd1;
        state_next   = (res_cnt_reg == cur_len - 16'd1) ? DONE : STREAM;
      end else begin
        fill_cnt_next = fill_cnt_reg + FILL_W'(1);
        state_next    = (fill_cnt_reg == FILL_W'(FILL_BEATS - 1)) ? STREAM : FILL;
      end
    end
  end

  // Controller state and frame counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      frame_len_reg <= '0;
      fill_cnt_reg  <= '0;
      res_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      frame_len_reg <= frame_len_next;
      fill_cnt_reg  <= fill_cnt_next;
      res_cnt_reg   <= res_cnt_next;
    end
  end

  // Each row gets a delay line. Row gi lags the last row by
  // (KERNEL_SIZE-1-gi)*VERTICAL_SKEW consumed beats, so the delay lines
  // advance only on consumed beats.
  for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
    localparam int DEPTH = (KERNEL_SIZE - 1 - gi) * VERTICAL_SKEW;
    logic [SUM_WIDTH-1:0] row_in;
    assign row_in = rowSumIn[gi*SUM_WIDTH +: SUM_WIDTH];

    if (DEPTH == 0) begin : g_direct
      assign aligned[gi] = row_in;
    end else begin : g_delay
      logic [SUM_WIDTH-1:0] dly_reg [DEPTH];

      // Shift on consumed beats. Clear on reset and at frame end.
      always_ff @(posedge clk) begin
        if (!rstn || state_reg == DONE) begin
          for (int k = 0; k < DEPTH; k++) dly_reg[k] <= '0;
        end else if (accept) begin
          dly_reg[0] <= row_in;
          for (int k = 1; k < DEPTH; k++) dly_reg[k] <= dly_reg[k-1];
        end
      end

      assign aligned[gi] = dly_reg[DEPTH-1];
    end
  end

  // Zero-extend and add the aligned row sums at full output width.
  always_comb begin
    sum_next = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      sum_next = sum_next + OUT_WIDTH'(aligned[r]);
    end
  end

  // Registered adder output. push_reg marks a result waiting to enter the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_reg  <= '0;
      push_reg <= 1'b0;
    end else begin
      push_reg <= produce;
      if (produce) sum_reg <= sum_next;
    end
  end

  assign convOut_valid = (count_reg != '0);
  assign pop           = convOut_valid && convOut_ready;
  assign fifo_full     = (count_reg == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push if a pop happens in the same cycle.
  assign push_ok       = push_reg && (!fifo_full || pop);

  // FIFO storage. It is not reset because the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= sum_reg;
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_reg && !push_ok) overflow_reg <= 1'b1;
    end
  end

  // One-cycle frame_done pulse, registered from the DONE state.
  always_ff @(posedge clk) begin
    if (!rstn) frame_done_reg <= 1'b0;
    else       frame_done_reg <= (state_reg == DONE);
  end

  // The head is gated to zero when empty, so stale storage never shows on the output.
  assign convOut    = convOut_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_psum_deskew_accum.sv
// Testbench for psum_deskew_accum with default parameters (3 rows, skew 2, FIFO depth 4).
// Directed frames; a scoreboard queue holds expected results, checked on each pop.
module tb_psum_deskew_accum;

  localparam int K  = 3;
  localparam int SW = 8 + 8 + K;
  localparam int OW = SW + $clog2(K);

  logic            clk;
  logic            rstn;
  logic            en;
  logic [15:0]     frameLen;
  logic [SW*K-1:0] rowSumIn;
  logic            rowSumIn_valid;
  logic [OW-1:0]   convOut;
  logic            convOut_valid;
  logic            convOut_ready;
  logic            frame_done;
  logic            overflow;

  psum_deskew_accum dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .frameLen       (frameLen),
    .rowSumIn       (rowSumIn),
    .rowSumIn_valid (rowSumIn_valid),
    .convOut        (convOut),
    .convOut_valid  (convOut_valid),
    .convOut_ready  (convOut_ready),
    .frame_done     (frame_done),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            fd_cnt   = 0;
  logic [OW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Row r carries test i's sum (r+1)*(3i+3) on beat i+2r, and zero on every other beat.
  function automatic logic [SW-1:0] rowval(input int r, input int b);
    int i;
    i = b - 2 * r;
    if (i >= 0 && i <= 4) return SW'((r + 1) * (3 * i + 3));
    return '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int b);
    for (int r = 0; r < K; r++) rowSumIn[r*SW +: SW] = rowval(r, b);
    rowSumIn_valid = 1'b1;
    step();
    rowSumIn_valid = 1'b0;
    rowSumIn       = '0;
  endtask

  task automatic push_expected(input int n);
    for (int t = 0; t < n; t++) sb.push_back(OW'(18 * (t + 1)));
  endtask

  task automatic wait_fd(input int target);
    int budget;
    budget = 60;
    while (fd_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    chk("frame_done_seen", fd_cnt, target);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_complete", sb.size(), 0);
  endtask

  // Scoreboard monitor: checks each pop against the queue, checks the head holds
  // while stalled, and counts frame_done cycles.
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_out   = '0;
  always @(negedge clk) begin
    if (rstn && prev_stall) begin
      chk("hold_valid", convOut_valid, 1);
      chk("hold_data", convOut, prev_out);
    end
    if (rstn && convOut_valid && convOut_ready) begin
      $display("pop convOut=%0d", convOut);
      if (sb.size() == 0) begin
        chk("unexpected_output", convOut, 0);
        if (convOut == '0) chk("unexpected_output_valid", convOut_valid, 0);
      end else begin
        chk("convOut_order", convOut, sb.pop_front());
      end
    end
    if (frame_done) fd_cnt++;
    prev_stall = rstn && convOut_valid && !convOut_ready;
    prev_out   = convOut;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; frameLen = 16'd0; rowSumIn = '0;
    rowSumIn_valid = 1'b0; convOut_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_convOut", convOut, 0);
    chk("reset_valid", convOut_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_overflow", overflow, 0);
    step();
    rstn = 1'b1;
    step();

    // Contiguous frame with the consumer always ready. Two trailing beats are
    // sent with en=0: one lands in DONE and one in IDLE, and both must be ignored.
    $display("frame A: contiguous beats, ready=1");
    convOut_ready = 1'b1; frameLen = 16'd5; en = 1'b1;
    push_expected(5);
    for (int b = 0; b < 9; b++) beat(b);
    en = 1'b0;
    beat(0);
    beat(1);
    wait_fd(1);
    wait_drain();
    repeat (5) step();
    chk("A_frame_done_once", fd_cnt, 1);
    chk("A_overflow", overflow, 0);

    // Two idle cycles after every beat, and en drops after beat 0 without ending the frame.
    $display("frame B: 2-cycle gaps, en dropped after beat 0");
    en = 1'b1;
    push_expected(5);
    for (int b = 0; b < 9; b++) begin
      beat(b);
      en = 1'b0;
      repeat (2) step();
    end
    wait_fd(2);
    wait_drain();
    repeat (5) step();
    chk("B_frame_done_once", fd_cnt, 2);
    chk("B_valid_empty", convOut_valid, 0);

    // Consumer stalled for the whole frame: four results are kept and the fifth is dropped.
    $display("frame C: ready=0, overflow expected");
    convOut_ready = 1'b0; en = 1'b1;
    push_expected(4);
    for (int b = 0; b < 9; b++) beat(b);
    en = 1'b0;
    wait_fd(3);
    repeat (3) step();
    @(negedge clk);
    chk("C_overflow_set", overflow, 1);
    chk("C_head_valid", convOut_valid, 1);
    chk("C_head_value", convOut, 18);
    step();
    convOut_ready = 1'b1;
    wait_drain();
    repeat (3) step();
    chk("C_empty_after_drain", convOut_valid, 0);
    chk("C_overflow_sticky", overflow, 1);

    // Reset clears the sticky overflow flag.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_overflow", overflow, 0);
    step();

    // Full FIFO with a push and a pop in the same cycle: nothing is dropped and order is kept.
    $display("frame D: simultaneous push/pop on full FIFO");
    convOut_ready = 1'b0; en = 1'b1;
    push_expected(5);
    for (int b = 0; b < 8; b++) beat(b);
    en = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("D_full_head", convOut, 18);
    step();
    beat(8);
    convOut_ready = 1'b1;
    step();
    convOut_ready = 1'b0;
    @(negedge clk);
    chk("D_overflow_clear", overflow, 0);
    chk("D_new_head", convOut, 36);
    step();
    wait_fd(4);
    convOut_ready = 1'b1;
    wait_drain();
    repeat (3) step();
    chk("D_empty_after_drain", convOut_valid, 0);

    // Reset in the middle of a frame, then a clean frame.
    $display("frame E: reset after beat 6, then clean frame");
    convOut_ready = 1'b0; en = 1'b1;
    for (int b = 0; b < 7; b++) beat(b);
    en = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("E_rst_convOut", convOut, 0);
    chk("E_rst_valid", convOut_valid, 0);
    chk("E_rst_frame_done", frame_done, 0);
    chk("E_rst_overflow", overflow, 0);
    step();
    @(negedge clk);
    chk("E_still_empty", convOut_valid, 0);
    chk("E_no_frame_done", fd_cnt, 4);
    step();
    convOut_ready = 1'b1; en = 1'b1;
    push_expected(5);
    for (int b = 0; b < 9; b++) beat(b);
    en = 1'b0;
    wait_fd(5);
    wait_drain();
    repeat (3) step();
    chk("E_frame_done_once", fd_cnt, 5);

    // frameLen=0: a single beat produces only a frame_done pulse, two cycles later.
    $display("frame F: frameLen=0");
    frameLen = 16'd0; en = 1'b1;
    rowSumIn_valid = 1'b1;
    rowSumIn = '1;
    step();
    rowSumIn_valid = 1'b0; rowSumIn = '0; en = 1'b0;
    @(negedge clk);
    chk("F_fd_cycle1", frame_done, 0);
    chk("F_valid_cycle1", convOut_valid, 0);
    step();
    @(negedge clk);
    chk("F_fd_cycle2", frame_done, 1);
    chk("F_valid_cycle2", convOut_valid, 0);
    step();
    @(negedge clk);
    chk("F_fd_cycle3", frame_done, 0);
    repeat (4) step();
    chk("F_frame_done_total", fd_cnt, 6);
    chk("F_no_output", convOut_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_deskew_accum.md
PSUM_DESKEW_ACCUM -- requirements
Module: psum_deskew_accum

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, meaning PE array rows and row-sum lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning pixel width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, meaning weight width.
REQ-004 SHALL have parameter VERTICAL_SKEW, default 2, meaning beats of delay between adjacent rows.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2).
REQ-006 SHALL derive SUM_WIDTH = DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE and OUT_WIDTH = SUM_WIDTH+$clog2(KERNEL_SIZE).
REQ-007 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-008 SHALL have port rstn, input, 1, reset; synchronous, active-low.
REQ-009 SHALL have port en, input, 1, frame enable; IDLE leaves only when en=1.
REQ-010 SHALL have port frameLen, input, 16, number of results per frame; latched on IDLE exit.
REQ-011 SHALL have port rowSumIn, input, SUM_WIDTH*KERNEL_SIZE, PE array row sums; row r at bits [r*SUM_WIDTH +: SUM_WIDTH].
REQ-012 SHALL have port rowSumIn_valid, input, 1, beat qualifier (PE array done).
REQ-013 SHALL have port convOut, output, OUT_WIDTH, FIFO head result.
REQ-014 SHALL have port convOut_valid, output, 1, FIFO not empty.
REQ-015 SHALL have port convOut_ready, input, 1, consumer accept; a pop occurs when valid and ready are both 1.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.
REQ-017 SHALL have port overflow, output, 1, sticky flag set when a result is dropped.

Function
REQ-018 SHALL implement states IDLE, FILL, STREAM and DONE.
REQ-019 IDLE -> FILL SHALL occur on en=1 and rowSumIn_valid=1; that beat is beat 0 and is captured; frameLen=0 SHALL instead go IDLE -> DONE.
REQ-020 SHALL delay row r by (KERNEL_SIZE-1-r)*VERTICAL_SKEW valid beats, so the aligned set for result t completes on beat t+(KERNEL_SIZE-1)*VERTICAL_SKEW.
REQ-021 SHALL hold delay registers and counters on cycles where rowSumIn_valid=0 (no bubbles inserted).
REQ-022 SHALL stay in FILL for beats 0..(KERNEL_SIZE-1)*VERTICAL_SKEW-1 and emit no result during FILL.
REQ-023 SHALL go FILL -> STREAM on the beat after the last fill beat; each valid beat in STREAM SHALL produce one result.
REQ-024 SHALL compute each result as the unsigned zero-extended sum of the KERNEL_SIZE aligned row sums at OUT_WIDTH, with no truncation.
REQ-025 SHALL write each result to the FIFO on the cycle after its qualifying beat (registered adder).
REQ-026 SHALL raise convOut_valid on the cycle after the FIFO write when the FIFO was empty.
REQ-027 SHALL go STREAM -> DONE after the frameLen-th result is produced; rowSumIn beats in DONE and IDLE SHALL be ignored.
REQ-028 DONE SHALL assert frame_done for exactly one cycle, clear the delay registers, then return to IDLE.
REQ-029 SHALL drop the result and set overflow when a push finds the FIFO full with no simultaneous pop; overflow SHALL clear only on reset.
REQ-030 SHALL accept a simultaneous push and pop when the FIFO is full, with no drop and occupancy unchanged.
REQ-031 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-032 SHALL keep convOut stable while convOut_valid=1 and convOut_ready=0.
REQ-033 en=0 mid-frame SHALL NOT abort the frame; beats continue to be consumed until DONE.

Reset
REQ-034 When rstn=0 at a clock edge, the next state SHALL be IDLE, with counters, delay registers and FIFO pointers at 0.
REQ-035 Under reset, convOut SHALL be 0, and convOut_valid, frame_done and overflow SHALL be 0.
REQ-036 Reset mid-frame SHALL discard all FIFO contents and partial sums; the next frame SHALL start clean.

Verification
REQ-037 Setup: KERNEL_SIZE=3, VERTICAL_SKEW=2, row r weights = r+1, test i data = [i,i+1,i+2], frameLen=5. The PE array feeds row r's test-i sum (r+1)(3i+3) on beat i+2r, zeros elsewhere, over 9 contiguous beats with ready=1. Required response: convOut sequence 18,36,54,72,90; then one frame_done pulse.
REQ-038 Same stimulus with 2-cycle valid=0 gaps inserted after every beat -> identical convOut sequence, no extra outputs.
REQ-039 convOut_ready=0 for the whole frame, FIFO_DEPTH=4 -> first four results held (18..72), 90 dropped, overflow=1; draining yields exactly 18,36,54,72.
REQ-040 FIFO full while a push and a pop occur in the same cycle -> no drop, overflow stays 0, order preserved.
REQ-041 rstn=0 for one cycle after beat 6 -> all outputs 0, FIFO empty; a following full frame yields 18..90 correctly.
REQ-042 frameLen=0 with en=1 and one valid beat -> frame_done pulse two cycles later, no convOut_valid.
